// File: rtl/register_file_pkg.sv
// register_file_pkg: shared defaults and types for the
// architectural register file.
package register_file_pkg;

    localparam int RF_DATA_WIDTH    = 64;
    localparam int RF_LOG2_NUM_REGS = 5;
    localparam int RF_NUM_REGS      = 2 ** RF_LOG2_NUM_REGS;

    typedef logic [RF_LOG2_NUM_REGS-1:0] reg_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0]    reg_data_t;

    // True when a write this edge targets the given read address.
    function automatic logic rf_hit(
        input logic      wen,
        input reg_addr_t waddr,
        input reg_addr_t raddr
    );
        return wen && (waddr == raddr);
    endfunction

endpackage

// File: rtl/register_file_rf_read_port.sv
// rf_read_port: one registered read port with a write-first
// bypass so a same-edge write is visible immediately.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int LOG2_NUM_REGS = RF_LOG2_NUM_REGS,
    parameter int NUM_REGS      = 2 ** LOG2_NUM_REGS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rd_en,
    input  logic [LOG2_NUM_REGS-1:0] raddr,
    input  logic                     write_en,
    input  logic [LOG2_NUM_REGS-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH-1:0]    rf [NUM_REGS],
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  bypass;

    // Pick the bypassed write data or the stored entry; hold when idle.
    always_comb begin
        rdata_d = rdata_q;
        bypass  = write_en && (waddr == raddr);
        if (rd_en) begin
            if (bypass) begin
                rdata_d = wdata;
            end else begin
                rdata_d = rf[raddr];
            end
        end
    end

    // Output register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/register_file.sv
// register_file: 32 x 64 flop-based register file with one
// write port and two registered, bypassed read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int LOG2_NUM_REGS = RF_LOG2_NUM_REGS,
    parameter int NUM_REGS      = 2 ** LOG2_NUM_REGS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               read_en,
    input  logic                     write_en,
    input  logic [LOG2_NUM_REGS-1:0] raddr_0,
    input  logic [LOG2_NUM_REGS-1:0] raddr_1,
    input  logic [LOG2_NUM_REGS-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata_0,
    output logic [DATA_WIDTH-1:0]    rdata_1
);

    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;

    // One-hot write decoder over the register rows.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = write_en &&
                (waddr == LOG2_NUM_REGS'(i));
        end
    end

    // Next-state per row: load wdata on select, else hold.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_d[i] = rf_q[i];
            if (wr_sel[i]) begin
                rf_d[i] = wdata;
            end
        end
    end

    // Each row is its own resettable flop bank.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_row
        // Row storage, cleared asynchronously.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rf_q[g] <= '0;
            end else begin
                rf_q[g] <= rf_d[g];
            end
        end
    end

    rf_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .LOG2_NUM_REGS(LOG2_NUM_REGS),
        .NUM_REGS     (NUM_REGS)
    ) u_rport_0 (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (read_en[0]),
        .raddr   (raddr_0),
        .write_en(write_en),
        .waddr   (waddr),
        .wdata   (wdata),
        .rf      (rf_q),
        .rdata   (rdata_0)
    );

    rf_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .LOG2_NUM_REGS(LOG2_NUM_REGS),
        .NUM_REGS     (NUM_REGS)
    ) u_rport_1 (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (read_en[1]),
        .raddr   (raddr_1),
        .write_en(write_en),
        .waddr   (waddr),
        .wdata   (wdata),
        .rf      (rf_q),
        .rdata   (rdata_1)
    );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random checks of register_file
// against an array-based reference model.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  read_en;
    logic        write_en;
    reg_addr_t   raddr_0;
    reg_addr_t   raddr_1;
    reg_addr_t   waddr;
    reg_data_t   wdata;
    reg_data_t   rdata_0;
    reg_data_t   rdata_1;

    int n_tests;
    int n_fail;

    reg_data_t m_rf [32];
    reg_data_t m_r0;
    reg_data_t m_r1;

    register_file dut (
        .clk     (clk),
        .reset_n (reset_n),
        .read_en (read_en),
        .write_en(write_en),
        .raddr_0 (raddr_0),
        .raddr_1 (raddr_1),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata_0 (rdata_0),
        .rdata_1 (rdata_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input reg_data_t act,
                       input reg_data_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: reset empties everything at once.
    always @(negedge reset_n) begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_r0 = '0;
        m_r1 = '0;
    end

    // Reference model: the write lands first, then enabled
    // ports read the updated array (write-first semantics).
    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            if (write_en) m_rf[waddr] = wdata;
            if (read_en[0]) m_r0 = m_rf[raddr_0];
            if (read_en[1]) m_r1 = m_rf[raddr_1];
        end
    end

    // Compare process: outputs vs model every cycle.
    always @(negedge clk) begin
        chk("cyc_rdata_0", rdata_0, m_r0);
        chk("cyc_rdata_1", rdata_1, m_r1);
    end

    task automatic step(input logic we, input reg_addr_t wa,
                        input reg_data_t wd, input logic [1:0] re,
                        input reg_addr_t a0, input reg_addr_t a1);
        write_en = we;
        waddr    = wa;
        wdata    = wd;
        read_en  = re;
        raddr_0  = a0;
        raddr_1  = a1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 2'b00, raddr_0, raddr_1);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) begin
            step(1'b0, '0, '0, 2'b11, reg_addr_t'(i),
                 reg_addr_t'(31 - i));
        end
    endtask

    initial begin
        reg_data_t rd;
        reg_addr_t ra;
        n_tests  = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_r0     = '0;
        m_r1     = '0;
        reset_n  = 1'b0;
        read_en  = '0;
        write_en = 1'b0;
        raddr_0  = '0;
        raddr_1  = '0;
        waddr    = '0;
        wdata    = '0;
        #100;
        chk("reset_rdata_0", rdata_0, 64'h0);
        chk("reset_rdata_1", rdata_1, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        read_all();
        chk("reset_reg31", rdata_0, 64'h0);

        step(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 2'b00, '0, '0);
        step(1'b0, '0, '0, 2'b01, 5'd5, 5'd0);
        chk("wr_rd_port0", rdata_0, 64'hDEADBEEF_CAFEF00D);
        chk("wr_rd_port1_zero", rdata_1, 64'h0);

        step(1'b0, '0, '0, 2'b00, 5'd6, 5'd0);
        chk("hold_port0", rdata_0, 64'hDEADBEEF_CAFEF00D);

        step(1'b1, 5'd3, 64'h1, 2'b00, 5'd6, 5'd0);
        step(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 5'd6, 5'd0);
        step(1'b0, '0, '0, 2'b11, 5'd3, 5'd31);
        chk("dual_port0", rdata_0, 64'h1);
        chk("dual_port1", rdata_1, 64'hFFFF_FFFF_FFFF_FFFF);

        step(1'b1, 5'd7, 64'hA5A5, 2'b11, 5'd7, 5'd7);
        chk("bypass_port0", rdata_0, 64'hA5A5);
        chk("bypass_port1", rdata_1, 64'hA5A5);

        step(1'b0, '0, '0, 2'b01, 5'd7, 5'd3);
        chk("after_bypass_store", rdata_0, 64'hA5A5);
        chk("port1_holds", rdata_1, 64'hA5A5);

        for (int n = 0; n < 3000; n++) begin
            rd = {$urandom, $urandom};
            ra = reg_addr_t'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                step(1'b1, ra, rd, 2'($urandom), ra, ra);
            end else begin
                step(1'($urandom), ra, rd, 2'($urandom),
                     reg_addr_t'($urandom), reg_addr_t'($urandom));
            end
        end

        for (int i = 0; i < 32; i++) begin
            step(1'b1, reg_addr_t'(i), reg_data_t'(i), 2'b00,
                 '0, '0);
        end
        step(1'b0, '0, '0, 2'b11, 5'd9, 5'd30);
        chk("fill_reg9", rdata_0, 64'd9);
        chk("fill_reg30", rdata_1, 64'd30);

        write_en = 1'b1;
        waddr    = 5'd12;
        wdata    = 64'h1234;
        read_en  = 2'b11;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_port0", rdata_0, 64'h0);
        chk("async_rst_port1", rdata_1, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        chk("post_rst_idle", rdata_0, 64'h0);
        read_all();
        step(1'b0, '0, '0, 2'b11, 5'd12, 5'd31);
        chk("lost_write_reg12", rdata_0, 64'h0);
        chk("post_rst_reg31", rdata_1, 64'h0);

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
